blink_code_tx: RTL and testbench
================================

Name: blink_code_tx

Overview:
- Transmit-side counterpart to the button/counter LED path: takes a small integer and sends it out on one LED as a burst of N blinks, then a long dark gap.
- Used to report status codes, counts and error numbers to a human watching the board.
- Upstream logic (counter, FSM, error latch) hands it a value over a valid/ready handshake; output drives an LED pin directly.

Parameters:
- WIDTH, 3, bit width of in_value; maximum code = 2^WIDTH-1.
- ON_CYCLES, 6000000, clk cycles the LED is lit per blink (>=1).
- OFF_CYCLES, 6000000, clk cycles dark between blinks within one code (>=1).
- GAP_CYCLES, 24000000, clk cycles dark after the last blink of a code (>=1).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- in_valid  input  1  in_value is valid.
- in_ready  output  1  block can accept a code this cycle.
- in_value  input  WIDTH  blink count to transmit.
- led  output  1  LED drive, 1 = lit.
- busy  output  1  a code is being transmitted (state != IDLE).
- done  output  1  one-cycle pulse on the final GAP cycle of a code.

Behaviour:
- Reset (rst low, async): state IDLE, timer 0, remaining count 0. Outputs: led 0, busy 0, done 0, in_ready 1. Reset mid-transmission aborts immediately; the LED goes dark with no completion pulse.
- States: IDLE, ON, OFF, GAP. led = 1 only in ON. busy = state != IDLE. All outputs are registered or decoded from state only; no combinational path from inputs to outputs.
- Handshake: transfer when in_valid && in_ready on a rising edge.
  - in_ready = 1 in IDLE, otherwise 0 (see the optional feature for the exception).
  - in_value is sampled only on transfer; later changes on in_value are ignored.
- Accept with v >= 1: next cycle ON, remaining = v.
- Accept with v = 0: next cycle GAP, so the LED stays dark for GAP_CYCLES.
- ON lasts exactly ON_CYCLES cycles. On exit, decrement remaining; go to OFF if remaining is still nonzero, otherwise go to GAP.
- OFF lasts exactly OFF_CYCLES cycles, then returns to ON.
- GAP lasts exactly GAP_CYCLES cycles. done = 1 on its last cycle, then IDLE.
- Latency:
  - LED first lights one cycle after the accept edge.
  - Total busy cycles for v >= 1: v*ON_CYCLES + (v-1)*OFF_CYCLES + GAP_CYCLES. For v = 0: GAP_CYCLES.
- Timer width: $clog2(max(ON_CYCLES, OFF_CYCLES, GAP_CYCLES)+1). The timer is loaded with (duration-1) on state entry and counts down to 0; expiry occurs at 0.
- Remaining counter is WIDTH bits wide. All-ones input is legal and must not wrap.

Optional Feature:
- Macro BLINK_CODE_REPEAT_EN.
- When defined:
  - On the final GAP cycle in_ready = 1 as well.
  - If a transfer occurs there, the new value starts next cycle (ON, or GAP for 0).
  - Otherwise the same latched value restarts (ON, or GAP for 0) and the block never returns to IDLE by itself.
  - done still pulses once per completed code.
- When undefined: after GAP always go to IDLE; in_ready is high only in IDLE.

Decomposition:
- Shared package blink_pkg holds the state enum typedef (blink_state_t: IDLE, ON, OFF, GAP) and the timer-width helper function.
- One natural sub-module: blink_timer (load, duration, expired). It is a down-counter reused for the ON, OFF and GAP periods.
- The FSM and remaining-count logic stay in blink_code_tx.

Test Plan (ON_CYCLES=2, OFF_CYCLES=3, GAP_CYCLES=5, WIDTH=3, accept edge = cycle 0):
- v=3, macro off -> led high cycles 1-2, 6-7 and 11-12; dark 13-17; done at 17; in_ready back high at 18.
- v=0 -> led never high; busy cycles 1-5; done at 5; in_ready high at 6.
- v=7 -> exactly 7 rising edges on led, busy for 7*2+6*3+5 = 37 cycles, no wrap.
- in_valid held high with v=1 while busy -> no second accept until in_ready rises; in_value changes mid-code have no effect.
- rst pulled low during cycle 7 of a v=3 code -> led 0, busy 0, done 0 and in_ready 1 immediately (asynchronous); a fresh v=1 after release gives led high for 2 cycles.
- BLINK_CODE_REPEAT_EN with v=2 and no further valid:
  - Pattern repeats with period 2*2+3+5 = 12 cycles.
  - done pulses once every 12 cycles.
  - Offering v=1 on a final GAP cycle switches to a single blink on the next cycle.

Source files
------------

// File: rtl/blink_pkg.sv
// rtl/blink_pkg.sv - shared FSM state type and timer sizing helper for the blink code transmitter
package blink_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ON,
        OFF,
        GAP
    } blink_state_t;

    function automatic int blink_timer_width(input int on_c, input int off_c, input int gap_c);
        int m;
        m = on_c;
        if (off_c > m) m = off_c;
        if (gap_c > m) m = gap_c;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/blink_timer.sv
// rtl/blink_timer.sv - down-counter shared by the ON, OFF and GAP periods
module blink_timer #(
    parameter int TW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_load,
    input  logic [TW-1:0] i_duration,
    output logic          o_expired
);

    logic [TW-1:0] r_count;

    // Loading duration-1 makes a period last exactly i_duration cycles including the load cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_duration - TW'(1);
        end else if (r_count != '0) begin
            r_count <= r_count - TW'(1);
        end
    end

    assign o_expired = (r_count == '0);

endmodule

// File: rtl/blink_code_tx.sv
// rtl/blink_code_tx.sv - sends a small integer as N LED blinks then a dark gap; BLINK_CODE_REPEAT_EN enables auto-repeat
module blink_code_tx
    import blink_pkg::*;
#(
    parameter int WIDTH      = 3,
    parameter int ON_CYCLES  = 6000000,
    parameter int OFF_CYCLES = 6000000,
    parameter int GAP_CYCLES = 24000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_value,
    output logic             led,
    output logic             busy,
    output logic             done
);

    localparam int            TW      = blink_timer_width(ON_CYCLES, OFF_CYCLES, GAP_CYCLES);
    localparam logic [TW-1:0] ON_DUR  = TW'(ON_CYCLES);
    localparam logic [TW-1:0] OFF_DUR = TW'(OFF_CYCLES);
    localparam logic [TW-1:0] GAP_DUR = TW'(GAP_CYCLES);

    blink_state_t     r_state;
    blink_state_t     w_next;
    logic [WIDTH-1:0] r_remaining;
    logic [WIDTH-1:0] w_remaining_next;
    logic             w_load;
    logic [TW-1:0]    w_duration;
    logic             w_expired;
    logic             w_last_gap;
    logic             w_accept;

    blink_timer #(
        .TW(TW)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .i_load    (w_load),
        .i_duration(w_duration),
        .o_expired (w_expired)
    );

    assign w_last_gap = (r_state == GAP) && w_expired;
    assign done       = w_last_gap;
    assign led        = (r_state == ON);
    assign busy       = (r_state != IDLE);

`ifdef BLINK_CODE_REPEAT_EN
    logic [WIDTH-1:0] r_code;

    assign in_ready = (r_state == IDLE) || w_last_gap;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_code <= '0;
        end else if (w_accept) begin
            r_code <= in_value;
        end
    end
`else
    assign in_ready = (r_state == IDLE);
`endif

    assign w_accept = in_valid && in_ready;

    always_comb begin
        w_next           = r_state;
        w_remaining_next = r_remaining;
        w_load           = 1'b0;
        w_duration       = ON_DUR;
        if (w_accept) begin
            w_remaining_next = in_value;
            w_load           = 1'b1;
            if (in_value != '0) begin
                w_next     = ON;
                w_duration = ON_DUR;
            end else begin
                w_next     = GAP;
                w_duration = GAP_DUR;
            end
        end else begin
            case (r_state)
                ON: begin
                    if (w_expired) begin
                        w_load           = 1'b1;
                        w_remaining_next = r_remaining - WIDTH'(1);
                        if (r_remaining != WIDTH'(1)) begin
                            w_next     = OFF;
                            w_duration = OFF_DUR;
                        end else begin
                            w_next     = GAP;
                            w_duration = GAP_DUR;
                        end
                    end
                end
                OFF: begin
                    if (w_expired) begin
                        w_load     = 1'b1;
                        w_next     = ON;
                        w_duration = ON_DUR;
                    end
                end
                GAP: begin
                    if (w_expired) begin
`ifdef BLINK_CODE_REPEAT_EN
                        // No new code offered: replay the latched one indefinitely.
                        w_load           = 1'b1;
                        w_remaining_next = r_code;
                        if (r_code != '0) begin
                            w_next     = ON;
                            w_duration = ON_DUR;
                        end else begin
                            w_next     = GAP;
                            w_duration = GAP_DUR;
                        end
`else
                        w_next = IDLE;
`endif
                    end
                end
                default: begin
                    w_next = r_state;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_remaining <= '0;
        end else begin
            r_state     <= w_next;
            r_remaining <= w_remaining_next;
        end
    end

endmodule

// File: tb/tb_blink_code_tx.sv
// tb/tb_blink_code_tx.sv - self-checking bench for blink_code_tx against a queue-based expected-waveform model
module tb_blink_code_tx;

    localparam int WIDTH = 3;
    localparam int ON_C  = 2;
    localparam int OFF_C = 3;
    localparam int GAP_C = 5;
`ifdef BLINK_CODE_REPEAT_EN
    localparam bit REPEAT = 1'b1;
`else
    localparam bit REPEAT = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             in_valid = 1'b0;
    logic [WIDTH-1:0] in_value = '0;
    logic             in_ready;
    logic             led;
    logic             busy;
    logic             done;

    int n_checks = 0;
    int n_pass   = 0;

    // Each entry is the expected {led, busy, done} for one future cycle.
    logic [2:0]       exp_q[$];
    logic [WIDTH-1:0] latched = '0;

    blink_code_tx #(
        .WIDTH     (WIDTH),
        .ON_CYCLES (ON_C),
        .OFF_CYCLES(OFF_C),
        .GAP_CYCLES(GAP_C)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_value(in_value),
        .led     (led),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    function automatic void push_code(input int v);
        for (int b = 1; b <= v; b++) begin
            for (int i = 0; i < ON_C; i++) exp_q.push_back(3'b110);
            if (b < v) for (int i = 0; i < OFF_C; i++) exp_q.push_back(3'b010);
        end
        for (int g = 1; g <= GAP_C; g++) exp_q.push_back((g == GAP_C) ? 3'b011 : 3'b010);
    endfunction

    function automatic bit model_ready();
        if (exp_q.size() == 0) return 1'b1;
        return REPEAT && exp_q[0][0];
    endfunction

    initial begin
        bit xfer;
        bit last;
        forever begin
            @(posedge clk);
            if (!rst) begin
                exp_q.delete();
            end else begin
                xfer = in_valid && model_ready();
                last = (exp_q.size() != 0) && exp_q[0][0];
                if (exp_q.size() != 0) void'(exp_q.pop_front());
                if (xfer) begin
                    latched = in_value;
                    push_code(int'(in_value));
                end else if (REPEAT && last) begin
                    push_code(int'(latched));
                end
            end
        end
    end

    initial begin
        logic [2:0] e;
        logic       er;
        forever begin
            @(negedge clk);
            e  = (exp_q.size() != 0) ? exp_q[0] : 3'b000;
            er = model_ready();
            chk("cyc_led", 64'(led), 64'(e[2]));
            chk("cyc_busy", 64'(busy), 64'(e[1]));
            chk("cyc_done", 64'(done), 64'(e[0]));
            chk("cyc_ready", 64'(in_ready), 64'(er));
        end
    end

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic send(input int v, input bit hold);
        in_valid = 1'b1;
        in_value = WIDTH'(v);
        @(posedge clk);
        #1;
        in_valid = hold;
    endtask

    // Bit k of each mask is the output sampled in cycle k after the accept edge.
    task automatic watch(input int n, input bit hold,
                         output logic [63:0] lm, output logic [63:0] bm,
                         output logic [63:0] dm, output logic [63:0] rm);
        lm = '0;
        bm = '0;
        dm = '0;
        rm = '0;
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            lm[k]    = led;
            bm[k]    = busy;
            dm[k]    = done;
            rm[k]    = in_ready;
            in_value = WIDTH'($urandom);
            in_valid = hold;
        end
    endtask

    initial begin
        logic [63:0] lm, bm, dm, rm;
        int          edges;
        bit          ok;

        #1;
        chk("rst_led", 64'(led), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;

`ifndef BLINK_CODE_REPEAT_EN
        do_reset();
        send(3, 1'b1);
        watch(18, 1'b1, lm, bm, dm, rm);
        in_valid = 1'b0;
        chk("v3_led_cycles", lm, 64'd6342);
        chk("v3_busy_cycles", bm, 64'd262142);
        chk("v3_done_cycle", dm, 64'd131072);
        chk("v3_ready_cycle", rm, 64'd262144);

        do_reset();
        send(0, 1'b0);
        watch(6, 1'b0, lm, bm, dm, rm);
        chk("v0_led", lm, 64'd0);
        chk("v0_busy", bm, 64'd62);
        chk("v0_done", dm, 64'd32);
        chk("v0_ready", rm, 64'd64);

        do_reset();
        send(7, 1'b0);
        watch(40, 1'b0, lm, bm, dm, rm);
        edges = 0;
        for (int k = 1; k <= 40; k++) if (lm[k] && !lm[k-1]) edges++;
        chk("v7_led_edges", 64'(edges), 64'd7);
        chk("v7_busy_count", 64'($countones(bm)), 64'd37);
        chk("v7_done_cycle", dm, 64'h0000_0020_0000_0000);
`else
        do_reset();
        send(2, 1'b0);
        watch(26, 1'b0, lm, bm, dm, rm);
        chk("rep_led_cycles", lm, 64'd101474502);
        chk("rep_done_cycles", dm, 64'd16781312);
        ok = 1'b0;
        for (int k = 0; k < 20 && !ok; k++) begin
            @(negedge clk);
            if (in_ready) ok = 1'b1;
        end
        chk("rep_ready_seen", 64'(ok), 64'd1);
        if (ok) begin
            in_valid = 1'b1;
            in_value = WIDTH'(1);
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            watch(9, 1'b0, lm, bm, dm, rm);
            chk("rep_switch_led", lm, 64'd774);
            chk("rep_switch_done", dm, 64'd128);
        end
`endif

        do_reset();
        send(3, 1'b0);
        repeat (6) @(posedge clk);
        #2;
        chk("mid_led_before_rst", 64'(led), 64'd1);
        rst = 1'b0;
        exp_q.delete();
        #1;
        chk("mid_rst_led", 64'(led), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_done", 64'(done), 64'd0);
        chk("mid_rst_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        send(1, 1'b0);
        watch(6, 1'b0, lm, bm, dm, rm);
        chk("post_rst_v1_led", lm, 64'd6);

        do_reset();
        for (int c = 0; c < 800; c++) begin
            @(posedge clk);
            #1;
            in_valid = ($urandom_range(0, 3) == 0);
            in_value = WIDTH'($urandom);
            if ($urandom_range(0, 199) == 0) begin
                rst = 1'b0;
                exp_q.delete();
                #2;
                rst = 1'b1;
            end
        end
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
